// File: rtl/bsg_muxi_pkg.sv
// ----------------------------------------------------------------------------
// bsg_muxi_pkg : shared helpers for the per-bit muxi family
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bsg_muxi_pkg;

  // A select that addresses no input yields this bit before any inversion.
  localparam logic c_oor_bit = 1'b0;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_muxi_n_gatestack.sv
// ----------------------------------------------------------------------------
// bsg_muxi_n_gatestack : combinational per-bit els_p:1 mux, optional invert
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bsg_muxi_n_gatestack
  import bsg_muxi_pkg::*;
#(
  parameter int width_p   = 64,
  parameter int els_p     = 4,
  parameter int invert_p  = 1,
  parameter int lg_els_lp = safe_clog2(els_p)
) (
  input  logic [els_p*width_p-1:0]     data_i,
  input  logic [width_p*lg_els_lp-1:0] sel_i,
  output logic [width_p-1:0]           data_o
);

  for (genvar b = 0; b < width_p; b++) begin : g_bit
    logic [lg_els_lp-1:0] w_sel;
    logic                 w_r;

    assign w_sel = sel_i[b*lg_els_lp +: lg_els_lp];

    always_comb begin
      w_r = c_oor_bit;
      for (int k = 0; k < els_p; k++) begin
        if (w_sel == lg_els_lp'(k)) w_r = data_i[k*width_p + b];
      end
    end

    assign data_o[b] = (invert_p != 0) ? ~w_r : w_r;
  end

endmodule

`default_nettype wire

// File: rtl/bsg_muxi_n_gatestack_fifo.sv
// ----------------------------------------------------------------------------
// bsg_muxi_n_gatestack_fifo : per-bit mux stage feeding a 2-entry output buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bsg_muxi_n_gatestack_fifo
  import bsg_muxi_pkg::*;
#(
  parameter int width_p    = 64,
  parameter int els_p      = 4,
  parameter int invert_p   = 1,
  localparam int lg_els_lp = safe_clog2(els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [els_p*width_p-1:0]     data_i,
  input  logic [width_p*lg_els_lp-1:0] sel_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i
);

  logic [width_p-1:0] w_mux;
  logic [width_p-1:0] mem_q [2];
  logic [1:0]         count_q, count_d;
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic               w_enq, w_deq;

  bsg_muxi_n_gatestack #(
    .width_p  (width_p),
    .els_p    (els_p),
    .invert_p (invert_p),
    .lg_els_lp(lg_els_lp)
  ) u_mux (
    .data_i(data_i),
    .sel_i (sel_i),
    .data_o(w_mux)
  );

  // Handshake outputs depend only on stored state (and reset), never on v_i/yumi_i.
  assign ready_o = ~reset_i & (count_q != 2'd2);
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[head_q];

  assign w_enq = v_i & ready_o;
  assign w_deq = v_o & yumi_i & ~reset_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (w_enq) tail_d = ~tail_q;
    if (w_deq) head_d = ~head_q;
    case ({w_enq, w_deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (w_enq) mem_q[tail_q] <= w_mux;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!$isunknown({v_i, yumi_i}));
      assert (!(yumi_i && !v_o));
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_muxi_n_gatestack_fifo.sv
// ----------------------------------------------------------------------------
// tb_bsg_muxi_n_gatestack_fifo : directed and scoreboard checks of the mux fifo
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bsg_muxi_n_gatestack_fifo;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic         yumi_i = 1'b0;
  logic [255:0] data_i = '0;
  logic [127:0] sel_i = '0;

  // A: els 4 inverted, B: els 3 inverted, C: els 4 true polarity.
  logic        rdy_a, v_a, rdy_b, v_b, rdy_c, v_c;
  logic [63:0] d_a, d_b, d_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bsg_muxi_n_gatestack_fifo #(.width_p(64), .els_p(4), .invert_p(1)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .sel_i(sel_i),
    .ready_o(rdy_a), .v_o(v_a), .data_o(d_a), .yumi_i(yumi_i));

  bsg_muxi_n_gatestack_fifo #(.width_p(64), .els_p(3), .invert_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i[191:0]), .sel_i(sel_i),
    .ready_o(rdy_b), .v_o(v_b), .data_o(d_b), .yumi_i(yumi_i));

  bsg_muxi_n_gatestack_fifo #(.width_p(64), .els_p(4), .invert_p(0)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .sel_i(sel_i),
    .ready_o(rdy_c), .v_o(v_c), .data_o(d_c), .yumi_i(yumi_i));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mux(input logic [255:0] d, input logic [127:0] s,
                                          input int els, input bit inv);
    logic [63:0] r;
    for (int b = 0; b < 64; b++) begin
      int sv;
      sv   = int'(s[b*2 +: 2]);
      r[b] = (sv < els) ? d[sv*64 + b] : 1'b0;
      if (inv) r[b] = ~r[b];
    end
    return r;
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    cyc(); cyc();
    checks++; if (v_a !== 1'b0) begin fails++; $display("FAIL reset_v_o actual=%0b required=0", v_a); end
    checks++; if (rdy_a !== 1'b0) begin fails++; $display("FAIL reset_ready_o actual=%0b required=0", rdy_a); end
    checks++; if (d_a !== 64'h0) begin fails++; $display("FAIL reset_data_o actual=%h required=0", d_a); end
    reset_i = 1'b0;
    #1;
    checks++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL release_ready_o actual=%0b required=1", rdy_a); end
  endtask

  task automatic test_latency();
    sel_i  = {64{2'b10}};
    data_i = '0;
    data_i[191:128] = 64'hFFFF0000FFFF0000;
    v_i = 1'b1;
    checks++; if (v_a !== 1'b0) begin fails++; $display("FAIL lat_pre_v_o actual=%0b required=0", v_a); end
    cyc();
    v_i = 1'b0; yumi_i = 1'b1;
    checks++; if (v_a !== 1'b1) begin fails++; $display("FAIL lat_v_o actual=%0b required=1", v_a); end
    checks++; if (d_a !== 64'h0000FFFF0000FFFF) begin fails++; $display("FAIL lat_data_a actual=%h required=0000ffff0000ffff", d_a); end
    checks++; if (d_b !== 64'h0000FFFF0000FFFF) begin fails++; $display("FAIL lat_data_b actual=%h required=0000ffff0000ffff", d_b); end
    checks++; if (d_c !== 64'hFFFF0000FFFF0000) begin fails++; $display("FAIL lat_data_c actual=%h required=ffff0000ffff0000", d_c); end
    cyc();
    yumi_i = 1'b0;
    checks++; if (v_a !== 1'b0) begin fails++; $display("FAIL lat_drain_v_o actual=%0b required=0", v_a); end
  endtask

  task automatic test_out_of_range();
    sel_i = '0;
    sel_i[11:10] = 2'b11;
    data_i = '0;
    v_i = 1'b1;
    cyc();
    v_i = 1'b0; yumi_i = 1'b1;
    checks++; if (d_b !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL oor_zero_b actual=%h required=ffffffffffffffff", d_b); end
    checks++; if (d_a !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL oor_zero_a actual=%h required=ffffffffffffffff", d_a); end
    data_i = '1;
    v_i = 1'b1;
    cyc();
    v_i = 1'b0; yumi_i = 1'b1;
    checks++; if (d_b !== 64'h0000000000000020) begin fails++; $display("FAIL oor_ones_b actual=%h required=0000000000000020", d_b); end
    checks++; if (d_a !== 64'h0) begin fails++; $display("FAIL oor_ones_a actual=%h required=0", d_a); end
    checks++; if (d_c !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL oor_ones_c actual=%h required=ffffffffffffffff", d_c); end
    cyc();
    yumi_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel_i = '0;
    data_i = '0;
    for (int n = 1; n <= 8; n++) begin
      data_i[63:0] = ~64'(n);
      v_i = 1'b1;
      yumi_i = (n > 1);
      checks++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL b2b_ready n=%0d actual=%0b required=1", n, rdy_a); end
      cyc();
      checks++; if (v_a !== 1'b1 || d_a !== 64'(n)) begin
        fails++; $display("FAIL b2b_data n=%0d actual=%0b/%h required=1/%h", n, v_a, d_a, 64'(n)); end
      checks++; if (d_c !== ~64'(n)) begin fails++; $display("FAIL b2b_data_c n=%0d actual=%h required=%h", n, d_c, ~64'(n)); end
    end
    v_i = 1'b0; yumi_i = 1'b1;
    cyc();
    yumi_i = 1'b0;
    checks++; if (v_a !== 1'b0) begin fails++; $display("FAIL b2b_drain_v_o actual=%0b required=0", v_a); end
  endtask

  task automatic test_backpressure();
    sel_i = '0; data_i = '0; yumi_i = 1'b0;
    data_i[63:0] = ~64'd1; v_i = 1'b1;
    cyc();
    data_i[63:0] = ~64'd2;
    checks++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL bp_ready1 actual=%0b required=1", rdy_a); end
    cyc();
    data_i[63:0] = ~64'd3;
    checks++; if (rdy_a !== 1'b0) begin fails++; $display("FAIL bp_full_ready actual=%0b required=0", rdy_a); end
    checks++; if (d_a !== 64'd1) begin fails++; $display("FAIL bp_head1 actual=%h required=1", d_a); end
    cyc();
    checks++; if (rdy_a !== 1'b0 || d_a !== 64'd1) begin
      fails++; $display("FAIL bp_hold actual=%0b/%h required=0/1", rdy_a, d_a); end
    yumi_i = 1'b1;
    cyc();
    checks++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL bp_ready_after_deq actual=%0b required=1", rdy_a); end
    checks++; if (d_a !== 64'd2) begin fails++; $display("FAIL bp_head2 actual=%h required=2", d_a); end
    cyc();
    v_i = 1'b0;
    checks++; if (v_a !== 1'b1 || d_a !== 64'd3) begin
      fails++; $display("FAIL bp_head3 actual=%0b/%h required=1/3", v_a, d_a); end
    cyc();
    yumi_i = 1'b0;
    checks++; if (v_a !== 1'b0) begin fails++; $display("FAIL bp_empty actual=%0b required=0", v_a); end
  endtask

  task automatic test_reset_full();
    sel_i = '0; data_i = '0; data_i[63:0] = ~64'hA5; v_i = 1'b1; yumi_i = 1'b0;
    cyc(); cyc();
    checks++; if (rdy_a !== 1'b0 || v_a !== 1'b1) begin
      fails++; $display("FAIL rf_full actual=%0b/%0b required=0/1", rdy_a, v_a); end
    reset_i = 1'b1; yumi_i = 1'b1;
    cyc();
    checks++; if (v_a !== 1'b0 || rdy_a !== 1'b0 || d_a !== 64'h0) begin
      fails++; $display("FAIL rf_in_reset actual=%0b/%0b/%h required=0/0/0", v_a, rdy_a, d_a); end
    reset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    #1;
    checks++; if (rdy_a !== 1'b1 || v_a !== 1'b0) begin
      fails++; $display("FAIL rf_release actual=%0b/%0b required=1/0", rdy_a, v_a); end
    cyc();
    checks++; if (v_a !== 1'b0) begin fails++; $display("FAIL rf_stale actual=%0b required=0", v_a); end
  endtask

  task automatic test_random();
    logic [63:0] qa[$], qb[$], qc[$];
    for (int c = 0; c < 10000; c++) begin
      checks++; if (v_a !== (qa.size() != 0) || v_b !== v_a || v_c !== v_a) begin
        fails++; $display("FAIL rnd_v_o cyc=%0d actual=%0b%0b%0b required=%0b", c, v_a, v_b, v_c, qa.size() != 0); end
      checks++; if (rdy_a !== (qa.size() != 2) || rdy_b !== rdy_a || rdy_c !== rdy_a) begin
        fails++; $display("FAIL rnd_ready cyc=%0d actual=%0b%0b%0b required=%0b", c, rdy_a, rdy_b, rdy_c, qa.size() != 2); end
      if (qa.size() != 0) begin
        checks++; if (d_a !== qa[0] || d_b !== qb[0] || d_c !== qc[0]) begin
          fails++; $display("FAIL rnd_data cyc=%0d actual=%h/%h/%h required=%h/%h/%h",
                            c, d_a, d_b, d_c, qa[0], qb[0], qc[0]); end
      end
      for (int w = 0; w < 8; w++) data_i[w*32 +: 32] = $urandom;
      for (int w = 0; w < 4; w++) sel_i[w*32 +: 32] = $urandom;
      v_i    = $urandom_range(0, 3) != 0;
      yumi_i = (qa.size() != 0) && ($urandom_range(0, 2) != 0);
      if (yumi_i) begin
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
      end
      if (v_i && (qa.size() + (yumi_i ? 1 : 0)) != 2) begin
        qa.push_back(ref_mux(data_i, sel_i, 4, 1'b1));
        qb.push_back(ref_mux(data_i, sel_i, 3, 1'b1));
        qc.push_back(ref_mux(data_i, sel_i, 4, 1'b0));
      end
      cyc();
    end
    v_i = 1'b0; yumi_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_out_of_range();
    test_back_to_back();
    test_backpressure();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
